// File: rtl/counter_pkg.sv
// Shared constants and helpers for the modulo step counter family.
package counter_pkg;

    localparam logic MODE_WRAP = 1'b0;
    localparam logic MODE_SAT  = 1'b1;

    localparam logic DIR_DOWN = 1'b0;
    localparam logic DIR_UP   = 1'b1;

    // Intermediate sums carry one extra bit so count + step never overflows.
    function automatic int unsigned sum_width(input int unsigned n);
        return n + 1;
    endfunction

endpackage

// File: rtl/mod_step_next.sv
// Combinational next-count calculation for a modulo counter with a
// pre-clamped step (s_i < MODULO), reporting wrap and saturation events.
module mod_step_next
    import counter_pkg::*;
#(
    parameter int unsigned N      = 4,
    parameter int unsigned MODULO = 10
) (
    input  logic [N-1:0] count_i,
    input  logic [N-1:0] s_i,
    input  logic         up_down_i,
    input  logic         mode_i,
    output logic [N-1:0] next_count_o,
    output logic         wrap_evt_o,
    output logic         sat_evt_o
);

    localparam int unsigned W     = sum_width(N);
    localparam logic [W-1:0] ModW = W'(MODULO);
    localparam logic [N-1:0] MaxN = N'(MODULO - 1);

    logic [W-1:0] cnt_w;
    logic [W-1:0] s_w;
    logic [W-1:0] sum_w;

    assign cnt_w = {1'b0, count_i};
    assign s_w   = {1'b0, s_i};
    assign sum_w = cnt_w + s_w;

    // Select the next count and raise at most one of the wrap/sat events.
    always_comb begin
        next_count_o = count_i;
        wrap_evt_o   = 1'b0;
        sat_evt_o    = 1'b0;
        if (up_down_i == DIR_UP) begin
            if (sum_w < ModW) begin
                next_count_o = N'(sum_w);
            end else if (mode_i == MODE_WRAP) begin
                next_count_o = N'(sum_w - ModW);
                wrap_evt_o   = 1'b1;
            end else begin
                // Reaching here implies s > 0, so every attempt past the limit flags.
                next_count_o = MaxN;
                sat_evt_o    = 1'b1;
            end
        end else begin
            if (cnt_w >= s_w) begin
                next_count_o = N'(cnt_w - s_w);
            end else if (mode_i == MODE_WRAP) begin
                next_count_o = N'(cnt_w + ModW - s_w);
                wrap_evt_o   = 1'b1;
            end else begin
                next_count_o = '0;
                sat_evt_o    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mod_step_counter.sv
// Up/down modulo counter with runtime step, wrap/saturate mode, synchronous
// load and registered wrap/saturation event pulses.
module mod_step_counter
    import counter_pkg::*;
#(
    parameter int unsigned N      = 4,
    parameter int unsigned MODULO = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         up_down,
    input  logic         mode,
    input  logic         load,
    input  logic [N-1:0] load_val,
    input  logic [N-1:0] step,
    output logic [N-1:0] count,
    output logic         tc,
    output logic         wrap_o,
    output logic         sat_o
);

    localparam int unsigned W     = sum_width(N);
    localparam logic [W-1:0] ModW = W'(MODULO);
    localparam logic [N-1:0] MaxN = N'(MODULO - 1);

    logic [N-1:0] count_q, count_d;
    logic         wrap_q, wrap_d;
    logic         sat_q, sat_d;

    logic [N-1:0] s_eff;
    logic [N-1:0] load_eff;
    logic [N-1:0] step_next;
    logic         step_wrap;
    logic         step_sat;

    // Out-of-range step and load values clamp to the top of the range.
    assign s_eff    = ({1'b0, step} < ModW) ? step : MaxN;
    assign load_eff = ({1'b0, load_val} < ModW) ? load_val : MaxN;

    mod_step_next #(
        .N      (N),
        .MODULO (MODULO)
    ) u_next (
        .count_i      (count_q),
        .s_i          (s_eff),
        .up_down_i    (up_down),
        .mode_i       (mode),
        .next_count_o (step_next),
        .wrap_evt_o   (step_wrap),
        .sat_evt_o    (step_sat)
    );

    // Priority mux: load over enabled step over hold; flags only from a step.
    always_comb begin
        count_d = count_q;
        wrap_d  = 1'b0;
        sat_d   = 1'b0;
        if (load) begin
            count_d = load_eff;
        end else if (en) begin
            count_d = step_next;
            wrap_d  = step_wrap;
            sat_d   = step_sat;
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
            wrap_q  <= 1'b0;
            sat_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            wrap_q  <= wrap_d;
            sat_q   <= sat_d;
        end
    end

    assign count  = count_q;
    assign wrap_o = wrap_q;
    assign sat_o  = sat_q;
    assign tc     = (up_down == DIR_UP) ? (count_q == MaxN) : (count_q == '0);

endmodule

// File: tb/tb_mod_step_counter.sv
// Scoreboard bench: two counters (MODULO=10 and MODULO=16, N=4) share one
// stimulus stream; an integer reference model predicts each edge's result.
module tb_mod_step_counter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic       up_down = 1'b0;
    logic       mode = 1'b0;
    logic       load = 1'b0;
    logic [3:0] load_val = '0;
    logic [3:0] step = '0;

    logic [3:0] count10, count16;
    logic       tc10, tc16, wrap10, wrap16, sat10, sat16;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int c10; int w10; int s10; int t10;
        int c16; int w16; int s16; int t16;
    } exp_t;
    exp_t exp_q[$];

    int m10 = 0;
    int m16 = 0;

    always #5 clk = ~clk;

    mod_step_counter #(.N(4), .MODULO(10)) dut10 (
        .clk(clk), .rst_n(rst_n), .en(en), .up_down(up_down), .mode(mode),
        .load(load), .load_val(load_val), .step(step),
        .count(count10), .tc(tc10), .wrap_o(wrap10), .sat_o(sat10)
    );

    mod_step_counter #(.N(4), .MODULO(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .en(en), .up_down(up_down), .mode(mode),
        .load(load), .load_val(load_val), .step(step),
        .count(count16), .tc(tc16), .wrap_o(wrap16), .sat_o(sat16)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: counting modulo m in plain integers.
    function automatic void model(input int m, input int c, input bit ld, input int lv,
                                  input bit e, input bit ud, input bit md, input int st,
                                  output int c_n, output int w, output int sa);
        int s;
        int t;
        c_n = c;
        w = 0;
        sa = 0;
        if (ld) begin
            c_n = (lv < m) ? lv : m - 1;
        end else if (e) begin
            s = (st < m) ? st : m - 1;
            if (ud) begin
                t = c + s;
                if (t < m) c_n = t;
                else if (!md) begin c_n = t - m; w = 1; end
                else begin c_n = m - 1; sa = 1; end
            end else begin
                t = c - s;
                if (t >= 0) c_n = t;
                else if (!md) begin c_n = t + m; w = 1; end
                else begin c_n = 0; sa = 1; end
            end
        end
    endfunction

    // Apply one cycle of inputs and queue the predicted post-edge outputs.
    task automatic drive(input bit ld, input int lv, input bit e, input bit ud,
                         input bit md, input int st);
        exp_t x;
        @(negedge clk);
        load = ld; load_val = 4'(lv); en = e; up_down = ud; mode = md; step = 4'(st);
        model(10, m10, ld, lv, e, ud, md, st, x.c10, x.w10, x.s10);
        model(16, m16, ld, lv, e, ud, md, st, x.c16, x.w16, x.s16);
        m10 = x.c10;
        m16 = x.c16;
        x.t10 = ud ? int'(x.c10 == 9) : int'(x.c10 == 0);
        x.t16 = ud ? int'(x.c16 == 15) : int'(x.c16 == 0);
        exp_q.push_back(x);
    endtask

    // Monitor: every clock edge presents a new result; compare against the head.
    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                x = exp_q.pop_front();
                chk("count10", int'(count10), x.c10);
                chk("wrap10", int'(wrap10), x.w10);
                chk("sat10", int'(sat10), x.s10);
                chk("tc10", int'(tc10), x.t10);
                chk("count16", int'(count16), x.c16);
                chk("wrap16", int'(wrap16), x.w16);
                chk("sat16", int'(sat16), x.s16);
                chk("tc16", int'(tc16), x.t16);
            end
        end
    end

    initial begin
        // Power-on reset.
        #12;
        chk("rst_count10", int'(count10), 0);
        chk("rst_count16", int'(count16), 0);
        chk("rst_flags", int'({wrap10, sat10, wrap16, sat16}), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Asynchronous reset mid-count.
        drive(1, 7, 0, 1, 0, 0);
        drive(0, 0, 0, 1, 0, 0);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_count10", int'(count10), 0);
        chk("async_rst_count16", int'(count16), 0);
        chk("async_rst_flags", int'({wrap10, sat10, wrap16, sat16}), 0);
        m10 = 0;
        m16 = 0;
        @(negedge clk);
        rst_n = 1'b1;
        drive(0, 0, 0, 1, 0, 0);
        drive(0, 0, 0, 0, 0, 0);

        // Up, wrap, step 3 from 0.
        for (int i = 0; i < 4; i++) drive(0, 0, 1, 1, 0, 3);
        // Down, saturate, step 2 from 5.
        drive(1, 5, 0, 0, 1, 2);
        for (int i = 0; i < 4; i++) drive(0, 0, 1, 0, 1, 2);
        // Load priority over en, and load clamp.
        drive(1, 13, 1, 1, 0, 3);
        drive(1, 4, 1, 1, 0, 3);
        // Zero step holds; oversized step clamps.
        drive(0, 0, 1, 1, 0, 0);
        drive(0, 0, 1, 1, 0, 15);
        drive(1, 1, 0, 0, 0, 0);
        drive(0, 0, 1, 0, 0, 4);
        // Full-range rollover both directions.
        drive(1, 15, 0, 1, 0, 0);
        drive(0, 0, 1, 1, 0, 1);
        drive(0, 0, 1, 0, 0, 1);
        // Saturate at top repeatedly; tc follows up_down while holding.
        drive(1, 15, 0, 1, 1, 0);
        drive(0, 0, 1, 1, 1, 1);
        drive(0, 0, 1, 1, 1, 5);
        drive(0, 0, 0, 0, 1, 5);
        drive(0, 0, 0, 1, 1, 5);

        // Randomized traffic.
        for (int i = 0; i < 300; i++) begin
            drive(bit'($urandom_range(0, 7) == 0), int'($urandom_range(0, 15)),
                  bit'($urandom_range(0, 3) != 0), bit'($urandom_range(0, 1)),
                  bit'($urandom_range(0, 1)), int'($urandom_range(0, 15)));
        end
        drive(0, 0, 0, 1, 0, 0);

        // Bounded drain of outstanding expectations.
        for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(posedge clk);
        #2;
        chk("queue_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mod_step_counter.md
Name: mod_step_counter

Overview:
Parametrised up/down modulo counter with runtime step size, selectable wrap or saturate mode, synchronous load of an arbitrary value, and wrap/saturation event flags.
Successor to the fixed-increment counter used for iteration and bit-position tracking in the signed multiplier datapath.
Targets multi-bit-per-cycle (radix-4/8) multiplier sequencing and general loop counting, where step and limit behaviour must be configurable.

Parameters:
N, 4, counter width in bits; legal range 2 to 16.
MODULO, 10, count range 0..MODULO-1; legal range 2 to 2^N.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
en  input  1  count enable
up_down  input  1  1 = count up, 0 = count down
mode  input  1  0 = wrap, 1 = saturate
load  input  1  synchronous load strobe; priority over en
load_val  input  N  value to load
step  input  N  increment/decrement amount per enabled cycle
count  output  N  current count, registered
tc  output  1  terminal count, combinational from count and up_down
wrap_o  output  1  registered one-cycle pulse: last update wrapped
sat_o  output  1  registered one-cycle pulse: last update clamped

Behaviour:
- Reset (rst_n low, asynchronous): count=0, wrap_o=0, sat_o=0. Release is synchronous to the next clk edge. Reset mid-count discards state.
- Update priority per clk edge: load > en > hold.
- Load:
  - count <= load_val if load_val < MODULO, else MODULO-1.
  - wrap_o=0, sat_o=0. en and step are ignored that cycle.
- Effective step: s = step if step < MODULO, else MODULO-1. s=0 with en=1 holds count with no flags.
- Up (en=1, up_down=1): sum = count + s, computed in N+1 bits to avoid overflow.
  - sum < MODULO: count <= sum.
  - sum >= MODULO, mode=0 (wrap): count <= sum - MODULO; wrap_o <= 1.
  - sum >= MODULO, mode=1 (saturate): count <= MODULO-1; sat_o <= 1, but only if count != MODULO-1 before the edge, or s > 0 and count is already MODULO-1. In other words, sat_o pulses on every enabled attempt to exceed the limit.
- Down (en=1, up_down=0):
  - count >= s: count <= count - s.
  - count < s, mode=0: count <= count + MODULO - s, computed in N+1 bits; wrap_o <= 1.
  - count < s, mode=1: count <= 0; sat_o <= 1.
- Hold (en=0, load=0): count unchanged; wrap_o=0, sat_o=0.
- wrap_o and sat_o are mutually exclusive. Each is high for exactly the one cycle following the causing edge.
- tc = (up_down ? count==MODULO-1 : count==0).
  - Purely combinational; follows up_down changes immediately.
  - Independent of mode and step.
- Latency: count reflects load or step one clk edge after the strobe.
- mode and up_down may change on any cycle; they take effect on the same edge.
- MODULO = 2^N: wrap arithmetic reduces to natural N-bit rollover. The N+1-bit path must still produce identical results.

Decomposition:
- Shared package counter_pkg:
  - MODE_WRAP = 1'b0, MODE_SAT = 1'b1.
  - DIR_DOWN = 1'b0, DIR_UP = 1'b1.
  - Width helper function for the N+1 intermediate sum.
- One combinational sub-module, mod_step_next:
  - Inputs: count, s, up_down, mode.
  - Outputs: next_count, wrap_evt, sat_evt.
  - Reusable by a future multi-channel counter bank.
- The top level holds only the registers, load/priority mux, step clamp and tc decode.

Test Plan:
- Reset and flags: assert rst_n=0 mid-count (count=7) asynchronously -> count=0, wrap_o=0, sat_o=0 before the next edge; release, en=0 -> count holds at 0.
- Up, wrap (N=4, MODULO=10, step=3, mode=0), from 0, en held for 4 edges -> count 3, 6, 9, 2; wrap_o high only in the cycle count=2; tc high while count=9.
- Down, saturate, from load_val=5, step=2, mode=1, up_down=0, 4 edges -> count 3, 1, 0, 0; sat_o high in the cycles after the 3rd and 4th edges; tc high at 0.
- Load priority and clamp: load=1, en=1, load_val=13 -> count=9 next cycle, no flags. Then load_val=4 with load=1 -> count=4.
- Step edge cases:
  - step=0, en=1 -> count holds, no flags.
  - step=15, up, wrap, count=4 -> s=9, sum=13 -> count=3, wrap_o=1.
  - Down, wrap, count=1, step=4 -> count=7, wrap_o=1.
- Full range (N=4, MODULO=16): up, wrap, step=1 from 15 -> count=0, wrap_o=1. Down from 0 -> count=15, wrap_o=1. Repeat for 20 random step/direction/mode cycles against a reference model.
